// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core:
// R-type funct codes and the mult/div sequencer states.
package cpu_pkg;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } md_state_t;

  // True for the four funct codes that start an operation.
  function automatic logic is_md_op(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Shared accumulator for shift-add multiply and restoring
// divide; one multiplier/quotient bit per step.
import cpu_pkg::*;

module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [WIDTH-1:0]   init,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   m_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     top;
  logic [WIDTH:0]     diff;

  // One iteration: add-and-shift right, or shift-left-and-trial-subtract.
  always_comb begin
    sum     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
    top     = acc_r[2*WIDTH-1:WIDTH-1];
    diff    = top - {1'b0, m_r};
    acc_nxt = acc_r;
    if (is_div) begin
      if (!diff[WIDTH])
        acc_nxt = {diff[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc_r[0])
        acc_nxt = {sum, acc_r[WIDTH-1:1]};
      else
        acc_nxt = {1'b0, acc_r[2*WIDTH-1:1]};
    end
  end

  // Load magnitudes in PREP, then iterate while stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_r   <= '0;
      acc_r <= '0;
    end else if (load) begin
      m_r   <= opnd;
      acc_r <= {{WIDTH{1'b0}}, init};
    end else if (step) begin
      acc_r <= acc_nxt;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers;
// sequencer IDLE -> PREP -> CALC -> FIX.
import cpu_pkg::*;

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_t          state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               is_div, is_sgn;
  logic               res_neg, rem_neg;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign accept = (state == IDLE) && start && is_md_op(funct);
  assign abs_a  = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
  assign abs_b  = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;
  assign busy   = (state != IDLE);

  md_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == PREP),
    .step    (state == CALC),
    .is_div  (is_div),
    .opnd    (is_div ? abs_b : abs_a),
    .init    (is_div ? abs_a : abs_b),
    .acc     (acc)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = PREP;
      PREP: state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign correction of the raw magnitude result.
  always_comb begin
    prod   = res_neg ? -acc : acc;
    quo    = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = rem_neg ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_r == '0) begin
        fix_hi = a_r;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  // Operand latch, signs, counter, HI/LO and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r     <= '0;
      b_r     <= '0;
      is_div  <= 1'b0;
      is_sgn  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_r    <= op_a;
            b_r    <= op_b;
            is_div <= funct[1];
            is_sgn <= ~funct[0];
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        PREP: begin
          res_neg <= is_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          rem_neg <= is_sgn & a_r[WIDTH-1];
          cnt     <= CW'(ITER - 1);
        end
        CALC: cnt <= cnt - 1'b1;
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath.
- Consumes the operand pair that the ALU operand selection produces: register A and the selected ALU B value.
- Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the 64-bit result in HI/LO.
- Services MFHI/MFLO reads and MTHI/MTLO writes; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; the datapath uses 32 only.
- ITER, WIDTH, number of CALC iterations (one bit per cycle).

Ports:
- clk  input  1  system clock, all state on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an operation; sampled only in IDLE
- funct  input  6  R-type funct field selecting the operation
- op_a  input  WIDTH  rs value (multiplicand / dividend)
- op_b  input  WIDTH  ALU B operand (multiplier / divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO write data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. While reset_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers clear. Asserting reset mid-operation aborts the operation; nothing is committed.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 with a valid funct: latch op_a, op_b and the op, go to PREP, busy=1 from the next edge.
  - start=1 with any other funct: ignored, busy stays 0.
- PREP (1 cycle):
  - Signed ops: take magnitudes of the operands; record result sign (a XOR b) and remainder sign (sign of a).
  - Unsigned ops: pass the operands through.
  - Load iteration counter = ITER-1.
- CALC (ITER cycles):
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - Counter decrements each cycle; leave CALC when the counter reaches 0.
- FIX (1 cycle):
  - Apply sign correction: negate the product, or negate quotient/remainder per their recorded signs.
  - Write hi/lo at the edge leaving FIX.
  - done=1 for exactly the following cycle, with busy=0 in that same cycle.
- Latency: start sampled at edge N -> hi/lo valid and done=1 after edge N+ITER+2 (N+34 for WIDTH=32).
- Result mapping:
  - MULT/MULTU: {hi,lo} = 64-bit product, two's complement for MULT.
  - DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: no exception, same latency; lo=all-ones, hi=op_a.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- start while busy: ignored.
- hi_we/lo_we:
  - Honoured only in IDLE; write takes effect at the next edge.
  - Ignored while busy.
  - If start and a write occur in the same IDLE cycle, start wins and the write is dropped.
  - hi_we and lo_we together write both registers with wdata.
- hi/lo hold their value between operations and writes; a back-to-back start in the done cycle is accepted.

Decomposition:
- Shared package (cpu_pkg): funct constants MULT=6'b011000, MULTU=6'b011001, DIV=6'b011010, DIVU=6'b011011, MFHI/MTHI/MFLO/MTLO; state typedef IDLE/PREP/CALC/FIX.
- One sub-module is natural: md_datapath, holding the shared accumulator/shift register and the add/subtract step. The top level keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for those 34 cycles, and done=1, busy=0 in the same cycle.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234, 34-cycle latency.
- Protocol collisions:
  - start in IDLE, then start with different operands mid-CALC -> second start ignored; first result committed.
  - hi_we=1, wdata=0xAAAA while busy -> hi unchanged.
  - start and lo_we in the same cycle -> write dropped.
- reset_n pulsed low at cycle 10 of CALC -> immediately busy=0, hi=lo=0, and no done pulse appears; a fresh MULTU 3x4 afterwards gives lo=12.
